// File: rtl/vdp_vram_arbiter.sv
// VRAM arbiter: the display DMA owns every cycle it asks for. A one-deep CPU
// read/write buffer is placed into VRAM cycles that the DMA leaves idle.
module vdp_vram_arbiter #(
  parameter int VRAM_SIZE       = 8192,
  parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE),
  parameter int STARVE_LIMIT    = 64
) (
  input  logic                       pxclk,
  input  logic                       reset,
  input  logic [VRAM_ADDR_WIDTH-1:0] dma_addr,
  input  logic                       dma_rd_tick,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]                 cpu_wdata,
  output logic                       cpu_busy,
  output logic                       cpu_done,
  output logic [7:0]                 cpu_rdata,
  input  logic                       starve_clr,
  output logic                       starve,
  output logic                       drop,
  output logic [VRAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                       ram_we,
  output logic [7:0]                 ram_din,
  input  logic [7:0]                 ram_dout
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, PEND, RDWAIT, DONE} state_t;

  state_t                     state;
  logic                       cpu_we_q;
  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr_q;
  logic [7:0]                 cpu_wdata_q;
  logic [CW-1:0]              wait_cnt;
  logic [CW-1:0]              wait_cnt_inc;

  always_comb begin
    wait_cnt_inc = (wait_cnt == CW'(STARVE_LIMIT)) ? wait_cnt : wait_cnt + 1'b1;
  end

  // Only the latched request copies reach the RAM port, never the live cpu_* inputs.
  always_comb begin
    ram_addr = dma_addr;
    ram_we   = 1'b0;
    ram_din  = cpu_wdata_q;
    if (!dma_rd_tick && state == PEND) begin
      ram_addr = cpu_addr_q;
      ram_we   = cpu_we_q;
    end
  end

  always_ff @(posedge pxclk) begin
    if (reset) begin
      state       <= IDLE;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= 8'h00;
      wait_cnt    <= '0;
      cpu_busy    <= 1'b0;
      cpu_done    <= 1'b0;
      cpu_rdata   <= 8'h00;
      starve      <= 1'b0;
      drop        <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      // Sets below come later in the block so they win over a same-cycle clear.
      if (starve_clr) begin
        starve <= 1'b0;
        drop   <= 1'b0;
      end
      if (cpu_req && state != IDLE) begin
        drop <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cpu_req) begin
            cpu_we_q    <= cpu_we;
            cpu_addr_q  <= cpu_addr;
            cpu_wdata_q <= cpu_wdata;
            cpu_busy    <= 1'b1;
            wait_cnt    <= '0;
            state       <= PEND;
          end
        end
        PEND: begin
          if (dma_rd_tick) begin
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc == CW'(STARVE_LIMIT)) begin
              starve <= 1'b1;
            end
          end else if (cpu_we_q) begin
            cpu_done <= 1'b1;
            cpu_busy <= 1'b0;
            state    <= DONE;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          // Data from the read issued last cycle; the DMA may own the port now.
          cpu_rdata <= ram_dout;
          cpu_done  <= 1'b1;
          cpu_busy  <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Bench for vdp_vram_arbiter: directed contention/starve/drop/reset cases plus
// random DMA and CPU traffic, checked by a scoreboard against a reference memory.
module tb_vdp_vram_arbiter;

  localparam int AW = 13;
  localparam int SL = 4;

  logic          pxclk = 1'b0;
  logic          reset;
  logic [AW-1:0] dma_addr;
  logic          dma_rd_tick;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_busy;
  logic          cpu_done;
  logic [7:0]    cpu_rdata;
  logic          starve_clr;
  logic          starve;
  logic          drop;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;

  vdp_vram_arbiter #(.VRAM_SIZE(8192), .VRAM_ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .pxclk(pxclk), .reset(reset), .dma_addr(dma_addr), .dma_rd_tick(dma_rd_tick),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .starve_clr(starve_clr), .starve(starve), .drop(drop),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 pxclk = ~pxclk;

  // Single-port synchronous VRAM, read-before-write.
  bit [7:0] vram [0:8191];
  always @(posedge pxclk) begin
    if (ram_we) vram[ram_addr] <= ram_din;
    ram_dout <= vram[ram_addr];
  end

  // Reference memory: CPU ops are serialized, so a read returns the last write accepted before it.
  bit [7:0] ref_mem [0:8191];

  typedef struct {
    bit we;
    int addr;
    int data;
    int req_cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dma_mode = 0;
  int dma_hold = 0;

  bit dma_log  [0:16383];
  bit we_log   [0:16383];
  int addr_log [0:16383];
  int din_log  [0:16383];

  always @(posedge pxclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle port rules plus scoreboard pop on every cpu_done.
  always @(negedge pxclk) begin
    dma_log[cyc[13:0]]  = dma_rd_tick;
    we_log[cyc[13:0]]   = ram_we;
    addr_log[cyc[13:0]] = int'(ram_addr);
    din_log[cyc[13:0]]  = int'(ram_din);
    if (!reset) begin
      chk("busy", int'(cpu_busy),
          int'(exp_q.size() != 0 && cyc > exp_q[0].req_cyc && !cpu_done));
      if (dma_rd_tick) begin
        chk("no_write_in_dma", int'(ram_we), 0);
        chk("dma_addr_route", int'(ram_addr), int'(dma_addr));
      end
      if (cpu_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got cpu_done=1 expected no done (cycle %0d)", cyc);
        end else begin
          exp_t e;
          int c;
          e = exp_q.pop_front();
          // The op goes out in the first DMA-free cycle after the request.
          c = e.req_cyc + 1;
          while (c < cyc && dma_log[c[13:0]]) c++;
          chk("done_latency", cyc, c + (e.we ? 1 : 2));
          chk("issue_we", int'(we_log[c[13:0]]), int'(e.we));
          chk("issue_addr", addr_log[c[13:0]], e.addr);
          if (e.we) chk("issue_din", din_log[c[13:0]], e.data);
          else      chk("read_data", int'(cpu_rdata), e.data);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge pxclk);
    #1;
    cpu_req    = 1'b0;
    starve_clr = 1'b0;
    if (dma_hold > 0) begin
      dma_rd_tick = 1'b1;
      dma_addr    = AW'($urandom_range(0, 8191));
      dma_hold--;
    end else if (dma_mode == 1) begin
      dma_rd_tick = ($urandom_range(0, 2) != 0);
      dma_addr    = AW'($urandom_range(0, 8191));
    end else begin
      dma_rd_tick = 1'b0;
    end
  endtask

  task automatic issue(input bit we, input int addr, input int data);
    exp_t e;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = AW'(addr);
    cpu_wdata = 8'(data);
    e.we      = we;
    e.addr    = addr;
    e.data    = we ? data : int'(ref_mem[addr]);
    e.req_cyc = cyc;
    exp_q.push_back(e);
    if (we) ref_mem[addr] = 8'(data);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      cycle();
      n++;
    end while (exp_q.size() != 0 && n < 200);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no cpu_done expected one within 200 cycles (cycle %0d)", cyc);
      exp_q.delete();
    end
  endtask

  task automatic cpu_op(input bit we, input int addr, input int data);
    cycle();
    issue(we, addr, data);
    wait_done();
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    dma_rd_tick = 1'b0; dma_addr = '0; starve_clr = 1'b0;
    repeat (3) cycle();
    @(negedge pxclk);
    chk("rst_busy", int'(cpu_busy), 0);
    chk("rst_done", int'(cpu_done), 0);
    chk("rst_rdata", int'(cpu_rdata), 0);
    chk("rst_starve", int'(starve), 0);
    chk("rst_drop", int'(drop), 0);
    cycle();
    reset = 1'b0;

    // Uncontended write then read-back.
    cpu_op(1'b1, 'h0123, 'hA5);
    cpu_op(1'b0, 'h0123, 0);

    // Read issued while DMA holds the port for 10 cycles.
    cpu_op(1'b1, 'h0456, 'h3C);
    dma_hold = 10;
    cpu_op(1'b0, 'h0456, 0);

    // Starvation: 6 blocked PEND cycles with a limit of 4.
    cycle();
    starve_clr = 1'b1;
    dma_hold = 7;
    cycle();
    issue(1'b0, 'h0123, 0);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      @(negedge pxclk);
      chk("starve_rise", int'(starve), int'(k >= 5));
    end
    wait_done();
    chk("starve_sticky", int'(starve), 1);
    starve_clr = 1'b1;
    cycle();
    @(negedge pxclk);
    chk("starve_clear", int'(starve), 0);

    // Drop: second request one cycle after the first is ignored.
    chk("drop_idle", int'(drop), 0);
    cycle();
    issue(1'b0, 'h0456, 0);
    cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'('h0456); cpu_wdata = 8'hEE;
    wait_done();
    chk("drop_set", int'(drop), 1);
    cpu_op(1'b0, 'h0456, 0);
    starve_clr = 1'b1;
    cycle();
    @(negedge pxclk);
    chk("drop_clear", int'(drop), 0);

    // Reset while the read sits in RDWAIT.
    cycle();
    issue(1'b0, 'h0123, 0);
    cycle();
    cycle();
    reset = 1'b1;
    exp_q.delete();
    cycle();
    reset = 1'b0;
    @(negedge pxclk);
    chk("rst_mid_busy", int'(cpu_busy), 0);
    chk("rst_mid_done", int'(cpu_done), 0);
    chk("rst_mid_rdata", int'(cpu_rdata), 0);
    repeat (4) cycle();
    cpu_op(1'b0, 'h0123, 0);

    // Random traffic against the reference memory.
    dma_mode = 1;
    for (int i = 0; i < 150; i++) begin
      bit we;
      int addr;
      we   = ($urandom_range(0, 1) == 1);
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 15));
      cpu_op(we, addr, int'($urandom_range(0, 255)));
    end
    dma_mode = 0;
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
